// File: rtl/clkdiv_pkg.sv
// +----------------------------------------------------------------------------+
// | Module      : clkdiv_pkg                                                   |
// | Description : Shared constants and helpers for the multi-channel clock /  |
// |               tick divider (clkdiv_multi, clkdiv_channel).                 |
// | Contents    : MODE_TOGGLE / MODE_PULSE mode encodings, default counter     |
// |               width and reset divisor, channel-select width helper.        |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

package clkdiv_pkg;

  // Per-channel output mode encoding (value of one bit of the mode vector)
  localparam logic MODE_TOGGLE = 1'b0;  // 50% square wave, period 2*div
  localparam logic MODE_PULSE  = 1'b1;  // one-cycle high strobe every div cycles

  // Defaults: 19-bit counter, 195313 = half-period of 128 Hz at 50 MHz
  localparam int CNT_W_DEF   = 19;
  localparam int DEF_DIV_DEF = 195313;

  // Width of a channel-select field; never narrower than one bit
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : clkdiv_pkg

`default_nettype wire

// File: rtl/clkdiv_channel.sv
// +----------------------------------------------------------------------------+
// | Module      : clkdiv_channel                                               |
// | Description : One divider channel: free-running counter with terminal      |
// |               count at div-1, shadowed divisor reload at period boundary,  |
// |               toggle or pulse output plus a tick strobe.                   |
// | Ports       : clk        - system clock, rising edge                       |
// |               rst_n      - asynchronous active-low reset                   |
// |               sync_i     - (CLKDIV_SYNC_EN only) restart counter           |
// |               en_i       - channel enable                                  |
// |               mode_i     - MODE_TOGGLE / MODE_PULSE                        |
// |               cfg_we_i   - accepted config transfer for this channel       |
// |               cfg_div_i  - divisor carried by that transfer                |
// |               clk_out_o  - divided output, registered                      |
// |               tick_o     - one-cycle strobe at terminal count, registered  |
// |               pending_o  - shadow divisor waiting for period boundary      |
// | Options     : CLKDIV_SYNC_EN adds sync_i and the resync path.              |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

module clkdiv_channel
  import clkdiv_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int DEF_DIV = DEF_DIV_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef CLKDIV_SYNC_EN
  input  logic             sync_i,
`endif
  input  logic             en_i,
  input  logic             mode_i,
  input  logic             cfg_we_i,
  input  logic [CNT_W-1:0] cfg_div_i,
  output logic             clk_out_o,
  output logic             tick_o,
  output logic             pending_o
);

  localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(DEF_DIV);

  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic             pending_q, pending_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;

  logic [CNT_W-1:0] w_div_eff;
  logic             w_terminal;

  // A zero divisor is treated as one so the terminal compare never underflows
  assign w_div_eff  = (div_q == '0) ? CNT_W'(1) : div_q;
  assign w_terminal = (count_q == (w_div_eff - CNT_W'(1)));

  always_comb begin
    count_d   = count_q;
    div_d     = div_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    clk_out_d = clk_out_q;
    tick_d    = 1'b0;

    // Default handling of a transfer: park it in the shadow register. The
    // branches below override this when the divisor may be loaded directly.
    // A transfer is only accepted while pending_q is low, so the apply paths
    // below never race a transfer that is already parked.
    if (cfg_we_i) begin
      shadow_d  = cfg_div_i;
      pending_d = 1'b1;
    end

`ifdef CLKDIV_SYNC_EN
    // Resync wins over everything; a transfer on this edge stays parked
    if (sync_i) begin
      count_d   = '0;
      clk_out_d = 1'b0;
      if (pending_q) begin
        div_d     = shadow_q;
        pending_d = 1'b0;
      end
    end else
`endif
    if (!en_i) begin
      count_d   = '0;
      clk_out_d = 1'b0;
      if (cfg_we_i) begin
        div_d     = cfg_div_i;
        pending_d = 1'b0;
      end else if (pending_q) begin
        div_d     = shadow_q;
        pending_d = 1'b0;
      end
    end else if (w_terminal) begin
      count_d   = '0;
      tick_d    = 1'b1;
      clk_out_d = (mode_i == MODE_PULSE) ? 1'b1 : ~clk_out_q;
      // Period boundary: the new divisor governs the period starting now
      if (cfg_we_i) begin
        div_d     = cfg_div_i;
        pending_d = 1'b0;
      end else if (pending_q) begin
        div_d     = shadow_q;
        pending_d = 1'b0;
      end
    end else begin
      count_d = count_q + CNT_W'(1);
      if (mode_i == MODE_PULSE) begin
        clk_out_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= '0;
      div_q     <= RST_DIV;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      count_q   <= count_d;
      div_q     <= div_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end

  assign clk_out_o = clk_out_q;
  assign tick_o    = tick_q;
  assign pending_o = pending_q;

endmodule : clkdiv_channel

`default_nettype wire

// File: rtl/clkdiv_multi.sv
// +----------------------------------------------------------------------------+
// | Module      : clkdiv_multi                                                 |
// | Description : NCH independent clock/tick dividers with a valid/ready       |
// |               divisor configuration port. Holds only config decode, the    |
// |               cfg_ready mux and the sync fan-out.                          |
// | Ports       : clk, rst_n          - clock / async active-low reset         |
// |               sync                - (CLKDIV_SYNC_EN only) resync all chans |
// |               en[NCH], mode[NCH]  - per-channel enable / mode              |
// |               cfg_valid/cfg_ready - config handshake                       |
// |               cfg_ch, cfg_div     - target channel / new divisor           |
// |               clk_out[NCH]        - divided outputs                        |
// |               tick[NCH]           - terminal-count strobes                 |
// | Options     : define CLKDIV_SYNC_EN to add the sync port.                  |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

module clkdiv_multi
  import clkdiv_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int DEF_DIV = DEF_DIV_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
`ifdef CLKDIV_SYNC_EN
  input  logic                     sync,
`endif
  input  logic [NCH-1:0]           en,
  input  logic [NCH-1:0]           mode,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [ch_width(NCH)-1:0] cfg_ch,
  input  logic [CNT_W-1:0]         cfg_div,
  output logic [NCH-1:0]           clk_out,
  output logic [NCH-1:0]           tick
);

  localparam int CH_W = ch_width(NCH);

  logic [NCH-1:0] w_pending;
  logic [NCH-1:0] w_cfg_we;

  // Out-of-range channel numbers are always ready and silently dropped
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      if (cfg_ch == CH_W'(i)) begin
        cfg_ready = ~w_pending[i];
      end
    end
  end

  generate
    for (genvar g = 0; g < NCH; g++) begin : g_ch
      assign w_cfg_we[g] = cfg_valid & cfg_ready & (cfg_ch == CH_W'(g));

      clkdiv_channel #(
        .CNT_W   (CNT_W),
        .DEF_DIV (DEF_DIV)
      ) u_channel (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef CLKDIV_SYNC_EN
        .sync_i    (sync),
`endif
        .en_i      (en[g]),
        .mode_i    (mode[g]),
        .cfg_we_i  (w_cfg_we[g]),
        .cfg_div_i (cfg_div),
        .clk_out_o (clk_out[g]),
        .tick_o    (tick[g]),
        .pending_o (w_pending[g])
      );
    end : g_ch
  endgenerate

endmodule : clkdiv_multi

`default_nettype wire

// File: tb/tb_clkdiv_multi.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_clkdiv_multi                                              |
// | Description : Directed self-checking bench for clkdiv_multi. Output        |
// |               sequences are captured MSB-first (oldest sample in the MSB)  |
// |               and compared against hand-computed bit patterns.             |
// | Options     : CLKDIV_SYNC_EN enables the resync section.                   |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_clkdiv_multi;

  localparam int NCH     = 4;
  localparam int CNT_W   = 19;
  localparam int DEF_DIV = 7;  // short reset divisor keeps the run brief

  logic             clk = 1'b0;
  logic             rst_n;
`ifdef CLKDIV_SYNC_EN
  logic             sync;
`endif
  logic [NCH-1:0]   en;
  logic [NCH-1:0]   mode;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [1:0]       cfg_ch;
  logic [CNT_W-1:0] cfg_div;
  logic [NCH-1:0]   clk_out;
  logic [NCH-1:0]   tick;

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] v;
  logic [63:0] v2;

  always #10 clk = ~clk;

  clkdiv_multi #(
    .NCH     (NCH),
    .CNT_W   (CNT_W),
    .DEF_DIV (DEF_DIV)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef CLKDIV_SYNC_EN
    .sync      (sync),
`endif
    .en        (en),
    .mode      (mode),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .clk_out   (clk_out),
    .tick      (tick)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Config transfer to a disabled channel (loads the divisor directly)
  task automatic cfg_direct(input logic [1:0] ch, input logic [CNT_W-1:0] d);
    cfg_ch    = ch;
    cfg_div   = d;
    cfg_valid = 1'b1;
    check_val("cfg_ready_idle", {63'd0, cfg_ready}, 64'd1);
    step();
    cfg_valid = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    en        = '0;
    mode      = '0;
    cfg_valid = 1'b0;
    cfg_ch    = '0;
    cfg_div   = '0;
`ifdef CLKDIV_SYNC_EN
    sync      = 1'b0;
`endif
    step();
    step();

    // ---------------- reset state ----------------
    check_val("rst_clk_out", {60'd0, clk_out}, 64'd0);
    check_val("rst_tick", {60'd0, tick}, 64'd0);
    check_val("rst_cfg_ready", {63'd0, cfg_ready}, 64'd1);

    // ---------------- reset divisor on ch3, toggle ----------------
    rst_n = 1'b1;
    en[3] = 1'b1;
    v = '0; v2 = '0;
    for (int i = 0; i < 14; i++) begin
      step();
      v  = {v[62:0], tick[3]};
      v2 = {v2[62:0], clk_out[3]};
    end
    check_val("def_tick3", v, 64'(14'b0000001_0000001));
    check_val("def_clk3", v2, 64'(14'b0000001_1111110));

    // ---------------- asynchronous reset mid-count ----------------
    repeat (10) step();
    check_val("pre_rst_clk3", {63'd0, clk_out[3]}, 64'd1);
    rst_n = 1'b0;
    #1;
    check_val("async_rst_clk_out", {60'd0, clk_out}, 64'd0);
    check_val("async_rst_tick", {60'd0, tick}, 64'd0);
    step();
    rst_n = 1'b1;
    v = '0;
    for (int i = 0; i < 7; i++) begin
      step();
      v = {v[62:0], tick[3]};
    end
    check_val("post_rst_tick3", v, 64'(7'b0000001));
    en[3] = 1'b0;
    step();

    // ---------------- toggle ch0, div=5 ----------------
    cfg_direct(2'd0, 19'd5);
    en[0] = 1'b1;
    mode[0] = 1'b0;
    v = '0; v2 = '0;
    for (int i = 0; i < 7; i++) begin
      step();
      v  = {v[62:0], tick[0]};
      v2 = {v2[62:0], clk_out[0]};
    end
    check_val("tog5_tick0", v, 64'(7'b00001_00));
    check_val("tog5_clk0", v2, 64'(7'b00001_11));
    en[0] = 1'b0;
    step();
    check_val("dis_clk0", {63'd0, clk_out[0]}, 64'd0);

    // ---------------- pulse ch1, div=3 ----------------
    cfg_direct(2'd1, 19'd3);
    en[1] = 1'b1;
    mode[1] = 1'b1;
    v = '0; v2 = '0;
    for (int i = 0; i < 9; i++) begin
      step();
      v  = {v[62:0], tick[1]};
      v2 = {v2[62:0], clk_out[1]};
    end
    check_val("pulse3_tick1", v, 64'(9'b001_001_001));
    check_val("pulse3_clk1", v2, 64'(9'b001_001_001));
    en[1] = 1'b0;
    step();

    // ---------------- div=1, pulse ----------------
    cfg_direct(2'd1, 19'd1);
    en[1] = 1'b1;
    v = '0;
    for (int i = 0; i < 6; i++) begin
      step();
      v = {v[62:0], tick[1]};
    end
    check_val("div1_tick1", v, 64'(6'b111111));
    en[1] = 1'b0;
    step();

    // ---------------- div=0 behaves as div=1, toggle ----------------
    cfg_direct(2'd1, 19'd0);
    en[1] = 1'b1;
    mode[1] = 1'b0;
    v = '0; v2 = '0;
    for (int i = 0; i < 6; i++) begin
      step();
      v  = {v[62:0], tick[1]};
      v2 = {v2[62:0], clk_out[1]};
    end
    check_val("div0_tick1", v, 64'(6'b111111));
    check_val("div0_clk1", v2, 64'(6'b101010));
    en[1] = 1'b0;
    step();

    // ------- glitch-free reload, terminal-edge transfer, disable with pending -------
    mode[0] = 1'b0;
    cfg_direct(2'd0, 19'd8);
    en[0] = 1'b1;
    cfg_ch = 2'd0;
    v = '0;
    for (int i = 1; i <= 34; i++) begin
      step();
      v = {v[62:0], tick[0]};
      case (i)
        2: begin  // count is 2: transfer lands mid-period and is parked
          cfg_div   = 19'd3;
          cfg_valid = 1'b1;
        end
        3: begin
          cfg_valid = 1'b0;
          check_val("reload_ready_low", {63'd0, cfg_ready}, 64'd0);
        end
        5: check_val("reload_ready_hold", {63'd0, cfg_ready}, 64'd0);
        8: check_val("reload_ready_back", {63'd0, cfg_ready}, 64'd1);
        16: begin  // next edge is terminal: direct load
          cfg_div   = 19'd5;
          cfg_valid = 1'b1;
        end
        17: begin
          cfg_valid = 1'b0;
          check_val("simul_ready", {63'd0, cfg_ready}, 64'd1);
        end
        28: begin
          cfg_div   = 19'd2;
          cfg_valid = 1'b1;
        end
        29: begin
          cfg_valid = 1'b0;
          check_val("dis_pend_ready_low", {63'd0, cfg_ready}, 64'd0);
          en[0] = 1'b0;
        end
        30: begin
          check_val("dis_pend_ready", {63'd0, cfg_ready}, 64'd1);
          check_val("dis_pend_clk0", {63'd0, clk_out[0]}, 64'd0);
          check_val("dis_pend_tick0", {63'd0, tick[0]}, 64'd0);
          en[0] = 1'b1;
        end
        default: ;
      endcase
    end
    check_val("reload_tick0_seq", v,
              64'(34'b0000000_1_00_1_00_1_00_1_0000_1_0000_1_0000101));
    en[0] = 1'b0;
    step();

    // ---------------- mode change toggle -> pulse on ch2 ----------------
    mode[2] = 1'b0;
    cfg_direct(2'd2, 19'd4);
    en[2] = 1'b1;
    v = '0;
    for (int i = 1; i <= 8; i++) begin
      step();
      v = {v[62:0], clk_out[2]};
      if (i == 5) mode[2] = 1'b1;
    end
    check_val("mode_chg_clk2", v, 64'(8'b00011001));
    en[2] = 1'b0;
    mode  = '0;
    step();

`ifdef CLKDIV_SYNC_EN
    // ---------------- resync ch0 / ch2 ----------------
    cfg_direct(2'd0, 19'd4);
    cfg_direct(2'd2, 19'd4);
    en[0] = 1'b1;
    step();
    step();
    en[2] = 1'b1;
    repeat (3) step();
    sync = 1'b1;
    step();
    sync = 1'b0;
    v = '0; v2 = '0;
    for (int i = 0; i < 8; i++) begin
      step();
      v  = {v[62:0], tick[0]};
      v2 = {v2[62:0], tick[2]};
    end
    check_val("sync_tick0", v, 64'(8'b0001_0001));
    check_val("sync_tick2", v2, 64'(8'b0001_0001));
    en = '0;
    step();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_clkdiv_multi

`default_nettype wire

// File: doc/clkdiv_multi.md
Name: clkdiv_multi

Overview:
- Parametrised multi-channel clock/tick divider.
- Each of NCH channels divides the 50 MHz clk by a runtime-programmable divisor.
- Each channel produces either a 50% square wave (toggle mode) or a one-cycle strobe (pulse mode), plus a tick strobe.
- Feeds button sampling, serial baud timing and servo PWM timebases from a single block; divisors are reprogrammed over a valid/ready config port without glitching the running period.

Parameters:
- NCH, 4, number of independent channels.
- CNT_W, 19, counter and divisor width in bits.
- DEF_DIV, 195313, reset divisor for every channel (half-period of 128 Hz at 50 MHz).

Ports:
- clk  in  1  system clock, 50 MHz, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  NCH  per-channel enable.
- mode  in  NCH  per-channel mode: 0 = toggle, 1 = pulse.
- cfg_valid  in  1  config request.
- cfg_ready  out  1  config accept; transfer occurs when cfg_valid and cfg_ready are both high at a rising edge.
- cfg_ch  in  max(1,$clog2(NCH))  target channel.
- cfg_div  in  CNT_W  new divisor.
- clk_out  out  NCH  divided output per channel, registered.
- tick  out  NCH  one-cycle strobe at each terminal count, registered.
- sync  in  1  present only with CLKDIV_SYNC_EN; see Optional Feature.

Behaviour:
- Reset (async, rst_n=0):
  - count=0, div=DEF_DIV, shadow=0, pending=0 for all channels.
  - clk_out=0, tick=0.
  - cfg_ready is combinational, so it reads 1 during reset.
- Per channel, en=0 (synchronous):
  - count<=0, clk_out<=0, tick<=0.
  - A pending divisor is applied immediately (div<=shadow, pending<=0).
- Per channel, en=1:
  - Terminal condition is count==div_eff-1, where div_eff = (div==0) ? 1 : div.
  - Not terminal: count<=count+1, tick<=0; clk_out<=0 in pulse mode, holds in toggle mode.
  - Terminal: count<=0, tick<=1; clk_out<=~clk_out in toggle mode, clk_out<=1 in pulse mode.
  - Also at terminal, if pending: div<=shadow, pending<=0. The new divisor governs the next period.
- Latency:
  - First terminal occurs on the div-th rising edge with en high, counted from en rising.
  - Toggle mode: clk_out period = 2*div cycles.
  - Tick period = div cycles in both modes.
- div=1: tick stays high continuously; toggle-mode clk_out = clk/2.
- Counter wraps only via the terminal condition, never via overflow.
- Config handshake:
  - cfg_ready = ~pending[cfg_ch], combinational from registers.
  - On transfer: shadow[cfg_ch]<=cfg_div, pending<=1.
  - Transfer on the same edge as that channel's terminal count: div<=cfg_div directly, pending stays 0.
  - Transfer while the channel is disabled: div<=cfg_div directly.
  - cfg_ch >= NCH: transfer accepted, ignored, cfg_ready=1.
- Mode change is sampled every cycle; no counter reset.
  - Toggle→pulse: clk_out drops to 0 on the next non-terminal edge.
  - Pulse→toggle: clk_out holds.
- Channels are fully independent; there is no cross-channel phase relation except via sync.

Optional Feature:
- Macro: CLKDIV_SYNC_EN.
- Defined:
  - sync port exists.
  - sync=1 at an edge, for every channel: count<=0, clk_out<=0, tick<=0, and any pending divisor is applied.
  - sync has priority over terminal and config direct-load. A config transfer on that edge still writes shadow/pending as normal.
  - All enabled channels with equal div are then phase-aligned.
- Undefined: no sync port, no resync logic.

Decomposition:
- Package clkdiv_pkg: mode constants (MODE_TOGGLE=0, MODE_PULSE=1), DEF_DIV default, CNT_W default.
- Sub-module clkdiv_channel holds one counter, div, shadow, pending, clk_out and tick. It is instantiated NCH times via generate.
- Top level contains only cfg decode, cfg_ready mux and sync fan-out.

Test Plan:
- Reset mid-count: reset asserted with count=100 → all outputs 0 on the same cycle; after release with en=1, div=195313 → first toggle after 195313 edges.
- Toggle: cfg ch0 div=5, en[0]=1, mode=0 → clk_out[0] toggles every 5 cycles (period 10); tick[0] high 1 cycle in 5.
- Pulse/div=1/div=0: ch1 mode=1 div=3 → clk_out[1] = 1 cycle high, 2 low. div=1 → tick constant 1. div=0 → behaves as div=1.
- Glitch-free reload: ch0 div=8 running; cfg div=3 at count=2 → cfg_ready[ch0] low until the terminal, current period completes at 8, next period is 3, cfg_ready returns 1.
- Simultaneous: cfg transfer exactly on the terminal edge → new div used for the very next period, pending never set. en dropped with a pending divisor → div applied, outputs 0.
- CLKDIV_SYNC_EN: ch0 div=4 and ch2 div=4 offset by 2 cycles; pulse sync → tick[0] and tick[2] coincide every 4 cycles afterward.
